// File: rtl/operand_stage_pkg.sv
// Shared types and constants for the operand-fetch/issue stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package operand_stage_pkg;

    localparam int DATA_W = 8;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // ALU op codes shared with the downstream ALU
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_PASS = 4'd7
    } alu_op_e;

    // True when a write strobe targets the given register
    function automatic logic addr_hit(input logic en, input reg_addr_t a, input reg_addr_t b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/operand_stage_reg_file.sv
// Architectural register file: two combinational reads, one write port.
// Latency: reads 0 cycles, write visible the cycle after the strobe.
// Backpressure: none, the write port always accepts.
module operand_stage_reg_file
    import operand_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  reg_addr_t waddr,
    input  data_t     wdata,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr0,
    output data_t     rdata1,
    output data_t     rdata0
);

    data_t regs_q [NREG];
    data_t regs_d [NREG];

    // Next-state of the array: only the addressed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata0 = regs_q[raddr0];

endmodule

// File: rtl/operand_stage.sv
// Operand fetch/issue: RAW scoreboard, regfile read, registered operands to the ALU.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: held op stays stable while out_ready=0; in_ready drops on hazard, stall or flush.
// Build option: OPERAND_WB_BYPASS_EN forwards same-cycle writeback into the operands.
module operand_stage
    import operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs0,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wb_en,
    input  alu_op_e           in_alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read0,
    output alu_op_e           alu_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wb_en,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    data_t           read1_q, read1_d;
    data_t           read0_q, read0_d;
    alu_op_e         alu_op_q, alu_op_d;
    reg_addr_t       out_rd_q, out_rd_d;
    logic            out_wb_en_q, out_wb_en_d;

    data_t           rf_rd1, rf_rd0;
    logic            fwd1, fwd0;
    logic            src_busy1, src_busy0;
    logic            hazard, stage_free, in_ready_int, accept;
    data_t           opnd1, opnd0;

    operand_stage_reg_file u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (in_rs1),
        .raddr0 (in_rs0),
        .rdata1 (rf_rd1),
        .rdata0 (rf_rd0)
    );

`ifdef OPERAND_WB_BYPASS_EN
    // A writeback landing this cycle satisfies the source directly
    assign fwd1 = addr_hit(wb_en, wb_addr, in_rs1);
    assign fwd0 = addr_hit(wb_en, wb_addr, in_rs0);
`else
    // Without forwarding the source waits until the write has reached the array
    assign fwd1 = 1'b0;
    assign fwd0 = 1'b0;
`endif

    assign src_busy1    = busy_q[in_rs1] & ~fwd1;
    assign src_busy0    = busy_q[in_rs0] & ~fwd0;
    assign hazard       = src_busy1 | src_busy0;
    assign stage_free   = ~out_valid_q | out_ready;
    assign in_ready_int = stage_free & ~hazard & ~flush;
    assign accept       = in_valid & in_ready_int;
    assign opnd1        = fwd1 ? wb_data : rf_rd1;
    assign opnd0        = fwd0 ? wb_data : rf_rd0;

    // Scoreboard: writeback and flush release, a new producer claims last so it wins a collision
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (flush && out_valid_q && out_wb_en_q) begin
            busy_d[out_rd_q] = 1'b0;
        end
        if (accept && in_wb_en) begin
            busy_d[in_rd] = 1'b1;
        end
    end

    // Output register: flush drops the held op, accept loads, consume empties
    always_comb begin
        out_valid_d = out_valid_q;
        read1_d     = read1_q;
        read0_d     = read0_q;
        alu_op_d    = alu_op_q;
        out_rd_d    = out_rd_q;
        out_wb_en_d = out_wb_en_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            read1_d     = opnd1;
            read0_d     = opnd0;
            alu_op_d    = in_alu_op;
            out_rd_d    = in_rd;
            out_wb_en_d = in_wb_en;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            read1_q     <= '0;
            read0_q     <= '0;
            alu_op_q    <= ALU_ADD;
            out_rd_q    <= '0;
            out_wb_en_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            read1_q     <= read1_d;
            read0_q     <= read0_d;
            alu_op_q    <= alu_op_d;
            out_rd_q    <= out_rd_d;
            out_wb_en_q <= out_wb_en_d;
        end
    end

    assign in_ready  = in_ready_int;
    assign out_valid = out_valid_q;
    assign read1     = read1_q;
    assign read0     = read0_q;
    assign alu_op    = alu_op_q;
    assign out_rd    = out_rd_q;
    assign out_wb_en = out_wb_en_q;

endmodule
